// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: one holding buffer per
// requester, round-robin drain onto a registered write port, RAW pending query.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clock,
  input  logic                      async_reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic [ADDR_W-1:0]         query_addr,
  output logic                      query_pending
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  buf_valid;
  logic [ADDR_W-1:0] buf_addr [N_REQ];
  logic [DATA_W-1:0] buf_data [N_REQ];
  logic [PTR_W-1:0]  rr_ptr;

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic              any_grant;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  next_ptr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  int                idx;

  // Round-robin scan starting at rr_ptr; first valid buffer wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    winner    = '0;
    win_addr  = '0;
    win_data  = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_grant && buf_valid[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
        win_addr   = buf_addr[idx];
        win_data   = buf_data[idx];
      end
    end
  end

  assign next_ptr = (int'(winner) == N_REQ - 1) ? '0 : winner + PTR_W'(1);

  // A buffer being drained this cycle may be refilled on the same edge.
  assign req_ready = async_reset ? (~buf_valid | grant) : '0;
  assign accept    = req_valid & req_ready;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the combinational grant/accept logic.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      buf_valid       <= '0;
      rr_ptr          <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          // Writes to x0 are dropped: the buffer simply ends up empty.
          buf_valid[i] <= (req_addr[i*ADDR_W +: ADDR_W] != '0);
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      rf_write_enable <= any_grant;
      if (any_grant) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
        rr_ptr        <= next_ptr;
      end
    end
  end

  // NOTE: buffer payloads carry no reset; buf_valid qualifies every use, so
  // resetting this storage would only add reset fanout.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        buf_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
        buf_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    query_pending = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (buf_valid[i] && (buf_addr[i] == query_addr)) query_pending = 1'b1;
    end
    if (rf_write_enable && (rf_write_addr == query_addr)) query_pending = 1'b1;
    if (query_addr == '0) query_pending = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued as
// stimulus is driven and compared as the write port fires.
module tb_regfile_wb_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                    clock = 1'b0;
  logic                    async_reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rf_write_enable;
  logic [ADDR_W-1:0]       rf_write_addr;
  logic [DATA_W-1:0]       rf_write_data;
  logic [ADDR_W-1:0]       query_addr;
  logic                    query_pending;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  regfile_wb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .async_reset    (async_reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .query_addr     (query_addr),
    .query_pending  (query_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every port write must match the head of the expected queue.
  always @(negedge clock) begin
    if (async_reset === 1'b1 && rf_write_enable === 1'b1) begin
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("write_payload", 64'({rf_write_addr, rf_write_data}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset();
    #2 async_reset = 1'b0;
    @(negedge clock);
    async_reset = 1'b1;
  endtask

  initial begin
    int i0, i1, w0, w1, max_w;
    logic f0, f1;

    // Reset with all requesters asserting valid (to x0, so nothing lingers).
    async_reset = 1'b0;
    req_valid   = 3'b111;
    req_addr    = '0;
    req_data    = '0;
    query_addr  = '0;
    #1;
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_we",    64'(rf_write_enable), 64'd0);
    check("reset_addr",  64'(rf_write_addr), 64'd0);
    check("reset_data",  64'(rf_write_data), 64'd0);
    repeat (2) @(negedge clock);
    async_reset = 1'b1;
    #1 check("ready_after_reset", 64'(req_ready), 64'b111);
    @(negedge clock);
    req_valid = '0;
    #1 check("x0_accepts_leave_empty", 64'(req_ready), 64'b111);

    // Single write from requester 0.
    @(negedge clock);
    req_valid = 3'b001;
    req_addr[0 +: ADDR_W] = 5'd4;
    req_data[0 +: DATA_W] = 32'hABCDE123;
    query_addr = 5'd4;
    exp_q.push_back({5'd4, 32'hABCDE123});
    #1 check("single_q_unaccepted", 64'(query_pending), 64'd0);
    @(negedge clock);
    req_valid = '0;
    #1;
    check("single_we_accept_cycle", 64'(rf_write_enable), 64'd0);
    check("single_q_buffered", 64'(query_pending), 64'd1);
    @(negedge clock);
    #1;
    check("single_we", 64'(rf_write_enable), 64'd1);
    check("single_addr", 64'(rf_write_addr), 64'd4);
    check("single_data", 64'(rf_write_data), 64'hABCDE123);
    check("single_q_on_port", 64'(query_pending), 64'd1);
    @(negedge clock);
    #1;
    check("single_we_done", 64'(rf_write_enable), 64'd0);
    check("single_q_done", 64'(query_pending), 64'd0);

    // Contention from reset: three requesters at once.
    pulse_reset();
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {32'h33, 32'h22, 32'h11};
    exp_q.push_back({5'd5, 32'h11});
    exp_q.push_back({5'd6, 32'h22});
    exp_q.push_back({5'd7, 32'h33});
    @(negedge clock);
    req_valid = '0;
    #1 check("cont_ready_0", 64'(req_ready), 64'b001);
    @(negedge clock);
    #1 check("cont_ready_1", 64'(req_ready), 64'b011);
    @(negedge clock);
    #1 check("cont_ready_2", 64'(req_ready), 64'b111);
    repeat (2) @(negedge clock);
    #1 check("cont_drained", 64'(exp_q.size()), 64'd0);

    // Round-robin between two continuously valid requesters.
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({5'd8, 32'hA000_0000 + 32'(k)});
      exp_q.push_back({5'd9, 32'hB000_0000 + 32'(k)});
    end
    i0 = 0; i1 = 0; w0 = 0; w1 = 0; max_w = 0;
    for (int cyc = 0; cyc < 40 && (i0 < 6 || i1 < 6); cyc++) begin
      req_valid[0] = (i0 < 6);
      req_valid[1] = (i1 < 6);
      req_valid[2] = 1'b0;
      req_addr[0 +: ADDR_W]      = 5'd8;
      req_addr[ADDR_W +: ADDR_W] = 5'd9;
      req_data[0 +: DATA_W]      = 32'hA000_0000 + 32'(i0);
      req_data[DATA_W +: DATA_W] = 32'hB000_0000 + 32'(i1);
      #1;
      f0 = req_valid[0] & req_ready[0];
      f1 = req_valid[1] & req_ready[1];
      @(negedge clock);
      if (f0) begin i0++; w0 = 0; end else if (req_valid[0]) w0++;
      if (f1) begin i1++; w1 = 0; end else if (req_valid[1]) w1++;
      if (w0 > max_w) max_w = w0;
      if (w1 > max_w) max_w = w1;
    end
    req_valid = '0;
    check("rr_accepts_0", 64'(i0), 64'd6);
    check("rr_accepts_1", 64'(i1), 64'd6);
    check("rr_max_wait_le2", 64'(max_w <= 2), 64'd1);
    repeat (3) @(negedge clock);
    #1 check("rr_drained", 64'(exp_q.size()), 64'd0);

    // Write to x0 is accepted but never reaches the port.
    req_valid = 3'b100;
    req_addr[2*ADDR_W +: ADDR_W] = 5'd0;
    req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    query_addr = 5'd0;
    #1;
    check("x0_ready", 64'(req_ready[2]), 64'd1);
    check("x0_q_presented", 64'(query_pending), 64'd0);
    @(negedge clock);
    req_valid = '0;
    #1;
    check("x0_q_after", 64'(query_pending), 64'd0);
    check("x0_not_buffered", 64'(req_ready), 64'b111);
    @(negedge clock);
    #1 check("x0_no_we_1", 64'(rf_write_enable), 64'd0);
    @(negedge clock);
    #1 check("x0_no_we_2", 64'(rf_write_enable), 64'd0);

    // Mid-operation reset with three buffers full; only the first grant
    // (requester 2, as the pointer sits at 2) reaches the port beforehand.
    req_valid = 3'b111;
    req_addr  = {5'd21, 5'd11, 5'd25};
    req_data  = {32'h2121_2121, 32'h1111_1111, 32'h2525_2525};
    exp_q.push_back({5'd21, 32'h2121_2121});
    query_addr = 5'd25;
    @(negedge clock);
    req_valid = '0;
    #1 check("mid_q_buffered", 64'(query_pending), 64'd1);
    @(negedge clock);
    #1;
    check("mid_we_before", 64'(rf_write_enable), 64'd1);
    check("mid_addr_before", 64'(rf_write_addr), 64'd21);
    #2 async_reset = 1'b0;
    #1;
    check("mid_we_cleared", 64'(rf_write_enable), 64'd0);
    check("mid_addr_cleared", 64'(rf_write_addr), 64'd0);
    check("mid_data_cleared", 64'(rf_write_data), 64'd0);
    check("mid_ready_in_reset", 64'(req_ready), 64'd0);
    check("mid_q_in_reset", 64'(query_pending), 64'd0);
    @(negedge clock);
    async_reset = 1'b1;
    #1;
    check("mid_ready_after", 64'(req_ready), 64'b111);
    check("mid_q_after", 64'(query_pending), 64'd0);
    repeat (4) @(negedge clock);
    #1;
    check("mid_no_write", 64'(rf_write_enable), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file among N_REQ write-back requesters, such as the ALU, load unit and CSR/vector unit.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffer per cycle onto registered write-port outputs.
- Exposes a pending-write query that the decode stage uses for RAW hazard stalls.

Parameters:
- N_REQ, 3, number of write-back requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- async_reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has a write pending.
- req_ready  out  N_REQ  requester i's buffer can accept this cycle.
- req_addr  in  N_REQ*ADDR_W  destination register for requester i; slice i = [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  write data for requester i; slice i = [i*DATA_W +: DATA_W].
- rf_write_enable  out  1  to regfile write_enable.
- rf_write_addr  out  ADDR_W  to regfile write_addr.
- rf_write_data  out  DATA_W  to regfile write_data.
- query_addr  in  ADDR_W  register being checked by decode.
- query_pending  out  1  a write to query_addr is buffered or on the port.

Behaviour:
- Reset (async_reset=0, asynchronous):
  - all buf_valid=0 and rr_ptr=0.
  - rf_write_enable=0, rf_write_addr=0, rf_write_data=0.
  - Any buffered or in-flight writes are discarded.
  - req_ready is 0 while reset is asserted.
- req_ready[i] is combinational: req_ready[i] = !buf_valid[i] | grant[i].
  - A buffer being drained this cycle can be refilled in the same cycle, so one write per requester per cycle is sustainable.
- Accept: on a rising edge with req_valid[i] & req_ready[i]:
  - if req_addr[i] != 0, buf i <= {addr, data} and buf_valid[i] <= 1;
  - if req_addr[i] == 0, the write is discarded (x0 hardwired) and buf_valid[i] <= 0 unless it is refilled.
- Arbitration is combinational over buf_valid:
  - scan from rr_ptr upward, modulo N_REQ; the first valid buffer wins and receives grant[winner].
  - At most one grant per cycle.
- Drain: on a rising edge with a grant:
  - rf_write_enable <= 1, rf_write_addr <= buf.addr, rf_write_data <= buf.data;
  - buf_valid[winner] <= 0 unless refilled in the same edge;
  - rr_ptr <= (winner+1) mod N_REQ.
- With no grant: rf_write_enable <= 0, addr/data hold their previous values, and rr_ptr is unchanged.
- Latency: accepted at edge T -> granted and driven on the port from edge T+1 -> committed in the regfile at edge T+2. Minimum two cycles from accept to register update.
- Ordering:
  - writes from the same requester commit in acceptance order;
  - no ordering is guaranteed across requesters;
  - if two requesters target the same register, the later commit wins. The upstream pipeline avoids this.
- query_pending = (query_addr != 0) & (any buf_valid[i] with buf.addr == query_addr, or rf_write_enable & rf_write_addr == query_addr).
  - It is combinational and does not include requests that are only presented on req_* and not yet accepted.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- Reset mid-operation: outputs clear immediately on assertion of async_reset, and no partial write reaches the regfile after the reset edge.

Test Plan:
- Reset → ready: hold async_reset=0 with req_valid=3'b111 → req_ready=0, rf_write_enable=0. Release reset → req_ready=3'b111.
- Single write: req0 addr=4, data=32'hABCDE123 for 1 cycle → rf_write_enable=1, addr=4, data=32'hABCDE123 exactly one cycle after the accept edge. query_addr=4 gives query_pending=1 for 2 cycles, then 0.
- Contention: all 3 requesters valid simultaneously with addrs 5/6/7 and data 32'h11/22/33 from reset → commits in order 5, 6, 7 on consecutive cycles.
  - req_ready[1] and req_ready[2] stay 0 until each requester's buffer is granted.
- Round-robin: req0 and req1 each continuously valid with new addrs 8 then 9, for 6 accepted writes each → grants alternate 0, 1, 0, 1, …; no requester waits more than 2 cycles.
- x0 discard: req2 addr=0, data=32'hDEADBEEF → accepted (ready=1), no rf_write_enable pulse, query_pending=0 for query_addr=0.
- Mid-op reset: three buffers full (addrs 25/11/21), pull async_reset low between clock edges → rf_write_enable drops to 0 immediately. After release, no write to 25, 11 or 21 occurs.
